dpi_result_sink: RTL and testbench
==================================

Name: dpi_result_sink

Overview:
- Downstream consumer of the DPI test module's 32-bit integer result and 1-bit boolean result.
- Captures each result pair on a sample strobe into a small FIFO.
- Drains pairs through a ready/valid interface to the checker/scoreboard side.
- Keeps running statistics (sample count, sum of flagged values) and a sticky drop error, so DPI round-trip results can be checked from RTL without a `$display`.

Parameters:
- DATA_W, 32: width of the integer result path.
- DEPTH, 4: FIFO entries. Must be a power of 2 and at least 2.
- SUM_W, 40: accumulator width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset.
- clear  in  1  synchronous soft clear.
- in_data  in  DATA_W  integer result from the DPI stage.
- in_flag  in  1  boolean result from the DPI stage.
- in_valid  in  1  sample strobe; the pair is valid this cycle.
- in_ready  out  1  FIFO can accept a pair.
- out_data  out  DATA_W  head-entry integer.
- out_flag  out  1  head-entry boolean.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts the head entry.
- level  out  $clog2(DEPTH)+1  current occupancy.
- count  out  16  accepted samples, saturating.
- sum  out  SUM_W  sum of in_data over accepted samples with in_flag=1.
- drop_err  out  1  sticky: a strobe was seen while not ready.

Behaviour:
- Clocking and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - level=0, count=0, sum=0, drop_err=0.
  - out_valid=0, out_data=0, out_flag=0.
  - in_ready=1.
  - Read and write pointers are 0.
- Reset mid-operation discards all FIFO contents immediately; no partial drain.
- Push: on in_valid && in_ready, the entry {in_flag, in_data} is written at wr_ptr, and wr_ptr increments.
- Pop: on out_valid && out_ready, rd_ptr increments.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap naturally; the extra MSB distinguishes full from empty.
- in_ready = !full. It is combinational from the pointers and does not depend on out_ready.
  - When full, a simultaneous pop does not enable a push in the same cycle.
- out_valid = !empty.
- out_data/out_flag show the head entry combinationally from storage. They are forced to 0 when empty.
- Latency: a pair pushed in cycle N appears at the outputs (out_valid=1) in cycle N+1 if the FIFO was empty.
- Data ordering is strict FIFO.
- Simultaneous push and pop when not full and not empty: both occur, and level is unchanged.
- level = wr_ptr - rd_ptr (modulo the pointer width), registered with the pointers.
- count increments by 1 on each push and saturates at 16'hFFFF.
- sum:
  - On a push with in_flag=1, sum <= sum + zero-extended in_data.
  - in_data is treated as unsigned.
  - The sum wraps modulo 2^SUM_W; no saturation.
- drop_err: set when in_valid && !in_ready. It stays set until clear or reset. The dropped sample does not affect count or sum.
- clear, synchronous, one cycle:
  - Resets pointers, level, count, sum and drop_err to 0.
  - Has priority over any push, pop or drop in the same cycle; those events are ignored.
  - in_ready is 1 in the cycle after clear.
- Storage contents are not reset; only the pointers are. Outputs are masked by the empty condition.

Decomposition:
- Package dpi_sink_pkg:
  - localparam DATA_W_DEF=32.
  - typedef struct packed {logic flag; logic [DATA_W_DEF-1:0] data;} dpi_result_t.
  - Function clog2_ptr for pointer width.
- Sub-module dpi_sink_fifo:
  - Parameterised DEPTH and entry type width.
  - Handles push, pop, full, empty, level and clear.
  - Holds no statistics.
- Top dpi_result_sink:
  - Instantiates dpi_sink_fifo.
  - Implements count, sum and drop_err.

Test Plan:
1. Reset then idle → out_valid=0, in_ready=1, level=0, count=0, sum=0, out_data=0.
2. Single push {flag=1, data=32'hFFFF_FFFF} with out_ready=0 → next cycle out_valid=1, out_data=FFFF_FFFF, out_flag=1, level=1, count=1, sum=40'h00_FFFF_FFFF.
3. Push 5 strobes back-to-back (data 1..5, flag=1) with out_ready=0, DEPTH=4:
   - in_ready=0 after the 4th push, 5th dropped.
   - level=4, count=4, sum=10, drop_err=1.
   - Then out_ready=1 drains 1,2,3,4 in order.
4. Simultaneous push and pop at level=2 for 8 cycles (data=cycle index, flag alternating 0/1) → level stays 2, FIFO order preserved, sum counts only the flag=1 values.
5. clear asserted in the same cycle as in_valid and out_ready at level=3 → next cycle level=0, out_valid=0, count=0, sum=0, drop_err=0, and the strobed sample is absent.
6. rst_n deasserted (asynchronously, between clock edges) while level=2 → outputs go to reset values immediately. After release, a push of data=7 appears as the head with count=1.

Source files
------------

// File: rtl/dpi_sink_pkg.sv
// dpi_sink_pkg: shared types and helpers for the DPI result sink
package dpi_sink_pkg;

    localparam int DATA_W_DEF = 32;

    typedef struct packed {
        logic                  flag;
        logic [DATA_W_DEF-1:0] data;
    } dpi_result_t;

    function automatic int clog2_ptr(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dpi_sink_fifo.sv
// dpi_sink_fifo: small pointer-based FIFO with soft clear, full/empty and level
module dpi_sink_fifo
    import dpi_sink_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          push,
    input  logic                          pop,
    input  logic [W-1:0]                  wdata,
    output logic [W-1:0]                  rdata,
    output logic                          full,
    output logic                          empty,
    output logic [clog2_ptr(DEPTH)-1:0]   level
);

    localparam int PW = clog2_ptr(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign level   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_ok);
            rd_ptr <= rd_ptr + PW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dpi_result_sink.sv
// dpi_result_sink: buffers DPI integer/boolean results and keeps running statistics
module dpi_result_sink
    import dpi_sink_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int SUM_W  = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_flag,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_flag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              count,
    output logic [SUM_W-1:0]         sum,
    output logic                     drop_err
);

    logic [DATA_W:0] head;
    logic            full;
    logic            empty;
    logic            push;

    dpi_sink_fifo #(.DEPTH(DEPTH), .W(DATA_W + 1)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (in_valid),
        .pop   (out_ready),
        .wdata ({in_flag, in_data}),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_flag  = head[DATA_W];
    assign out_data  = head[DATA_W-1:0];
    assign push      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            sum      <= '0;
            drop_err <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            sum      <= '0;
            drop_err <= 1'b0;
        end else begin
            if (push && count != 16'hFFFF)
                count <= count + 16'd1;
            if (push && in_flag)
                sum <= sum + SUM_W'(in_data);
            if (in_valid && !in_ready)
                drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dpi_result_sink.sv
// tb_dpi_result_sink: directed stimulus with a queue scoreboard checked by a monitor
module tb_dpi_result_sink;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_flag = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_flag;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  level;
    logic [15:0] count;
    logic [39:0] sum;
    logic        drop_err;

    int n_chk = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];

    dpi_result_sink #(.DATA_W(32), .DEPTH(4), .SUM_W(40)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_data   (in_data),
        .in_flag   (in_flag),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_flag  (out_flag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .count     (count),
        .sum       (sum),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic f, input logic [31:0] d, input logic exp_accept);
        in_valid = v;
        in_flag  = f;
        in_data  = d;
        if (v && exp_accept)
            exp_q.push_back({f, d});
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        while (out_valid && guard < 10) begin
            step();
            guard++;
        end
        out_ready = 1'b0;
        chk("drain_done", {63'd0, out_valid}, 64'd0);
    endtask

    // Monitor: every handshake the DUT will complete on the next edge must match the queue head
    always @(negedge clk) begin
        if (rst_n && !clear && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {31'd0, out_flag, out_data}, 64'h1_DEAD_BEEF);
            end else begin
                chk("fifo_head", {31'd0, out_flag, out_data}, {31'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        // 1: reset and idle
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_level", {61'd0, level}, 64'd0);
        chk("rst_count", {48'd0, count}, 64'd0);
        chk("rst_sum", {24'd0, sum}, 64'd0);
        chk("rst_out_data", {32'd0, out_data}, 64'd0);
        chk("rst_drop_err", {63'd0, drop_err}, 64'd0);

        // 2: single push of all-ones with flag set
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t2_out_data", {32'd0, out_data}, 64'hFFFF_FFFF);
        chk("t2_out_flag", {63'd0, out_flag}, 64'd1);
        chk("t2_level", {61'd0, level}, 64'd1);
        chk("t2_count", {48'd0, count}, 64'd1);
        chk("t2_sum", {24'd0, sum}, 64'h00_FFFF_FFFF);
        drain();

        // 3: overfill by one, then drain in order
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t3_clr_count", {48'd0, count}, 64'd0);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1, 32'(i), i <= 4);
            step();
            if (i == 4)
                chk("t3_full_in_ready", {63'd0, in_ready}, 64'd0);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t3_level", {61'd0, level}, 64'd4);
        chk("t3_count", {48'd0, count}, 64'd4);
        chk("t3_sum", {24'd0, sum}, 64'd10);
        chk("t3_drop_err", {63'd0, drop_err}, 64'd1);
        drain();

        // 4: steady push+pop at level 2
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t4_clr_drop_err", {63'd0, drop_err}, 64'd0);
        drive(1'b1, 1'b0, 32'hA0, 1'b1);
        step();
        drive(1'b1, 1'b0, 32'hA1, 1'b1);
        step();
        chk("t4_pre_level", {61'd0, level}, 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i[0], 32'(i), 1'b1);
            step();
            chk("t4_level", {61'd0, level}, 64'd2);
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        out_ready = 1'b0;
        chk("t4_sum", {24'd0, sum}, 64'd16);
        chk("t4_count", {48'd0, count}, 64'd10);
        drain();

        // 5: clear beats simultaneous push and pop
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 32'h30 + 32'(i), 1'b1);
            step();
        end
        chk("t5_pre_sum", {24'd0, sum}, 64'h96);
        chk("t5_pre_level", {61'd0, level}, 64'd3);
        clear = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 1'b1, 32'h55, 1'b0);
        step();
        clear = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        exp_q.delete();
        chk("t5_level", {61'd0, level}, 64'd0);
        chk("t5_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_count", {48'd0, count}, 64'd0);
        chk("t5_sum", {24'd0, sum}, 64'd0);
        chk("t5_drop_err", {63'd0, drop_err}, 64'd0);
        chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t5_out_data", {32'd0, out_data}, 64'd0);

        // 6: asynchronous reset mid-operation
        drive(1'b1, 1'b0, 32'h61, 1'b1);
        step();
        drive(1'b1, 1'b0, 32'h62, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_pre_level", {61'd0, level}, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("t6_rst_level", {61'd0, level}, 64'd0);
        chk("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("t6_rst_count", {48'd0, count}, 64'd0);
        chk("t6_rst_out_data", {32'd0, out_data}, 64'd0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 32'h7, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        chk("t6_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t6_out_data", {32'd0, out_data}, 64'h7);
        chk("t6_count", {48'd0, count}, 64'd1);
        chk("t6_level", {61'd0, level}, 64'd1);
        drain();

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
